// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad matrix scanner.
// Holds the scan FSM state encoding and the key-code mapping.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    PRESS_DB,
    HELD,
    RELEASE_DB
  } kp_state_e;

  function automatic int unsigned kp_code(
    input int unsigned row,
    input int unsigned col,
    input int unsigned ncols
  );
    return row * ncols + col;
  endfunction

endpackage

// File: rtl/col_synchronizer.sv
// Two-flop synchroniser for the raw, active-low column lines.
// Resets to all ones so an idle keypad reads as "no key".
module col_synchronizer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Row-scanning keypad matrix decoder with press/release debounce.
// Define KEYPAD_AUTOREPEAT_EN to re-strobe key_valid while a key is held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int REPEAT_CYCLES   = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [COLS-1:0]               cols,
  output logic [ROWS-1:0]               rows,
  output logic [$clog2(ROWS*COLS)-1:0]  key_code,
  output logic                          key_valid,
  output logic                          key_held
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int KW = $clog2(ROWS*COLS);
  localparam int DW = $clog2(SCAN_DIV) + 1;
  localparam int BW = $clog2(DEBOUNCE_CYCLES) + 1;

  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DB_LAST    = BW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

  if (ROWS < 2 || COLS < 2 || SCAN_DIV < 4 ||
      DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_cfg
    $error("keypad_scanner: illegal parameter set");
  end

  kp_state_e       state_q, state_d;
  logic [RW-1:0]   row_q, row_d, row_next;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [BW-1:0]   db_q, db_d;
  logic [CW-1:0]   col_q, col_d, low_col;
  logic [KW-1:0]   code_d;
  logic            valid_d, held_d;
  logic [COLS-1:0] cols_s;
  logic            cap_bit;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int PW = $clog2(REPEAT_CYCLES) + 1;
  localparam logic [PW-1:0] REP_LAST = PW'(REPEAT_CYCLES - 1);
  logic [PW-1:0] rep_q, rep_d;
`endif

  col_synchronizer #(
    .W (COLS)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (cols),
    .q     (cols_s)
  );

  assign row_next = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
  assign cap_bit  = cols_s[col_q];
  assign rows     = ~(ROWS'(1) << row_q);

  // Lowest-index closed column wins when several are low.
  always_comb begin
    low_col = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!cols_s[c]) low_col = CW'(c);
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    dwell_d = dwell_q;
    db_d    = db_q;
    col_d   = col_q;
    code_d  = key_code;
    valid_d = 1'b0;
    held_d  = key_held;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_d   = '0;
`endif
    unique case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (&cols_s) begin
            row_d = row_next;
          end else begin
            col_d   = low_col;
            db_d    = '0;
            state_d = PRESS_DB;
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      PRESS_DB: begin
        if (cap_bit) begin
          db_d    = '0;
          dwell_d = '0;
          row_d   = row_next;
          state_d = SCAN;
        end else if (db_q == DB_LAST) begin
          db_d    = '0;
          code_d  = KW'(kp_code(32'(row_q), 32'(col_q), COLS));
          valid_d = 1'b1;
          held_d  = 1'b1;
          state_d = HELD;
        end else begin
          db_d = db_q + BW'(1);
        end
      end
      HELD: begin
        if (cap_bit) begin
          db_d    = '0;
          state_d = RELEASE_DB;
`ifdef KEYPAD_AUTOREPEAT_EN
        end else if (rep_q == REP_LAST) begin
          valid_d = 1'b1;
        end else begin
          rep_d = rep_q + PW'(1);
`endif
        end
      end
      RELEASE_DB: begin
        if (!cap_bit) begin
          db_d    = '0;
          state_d = HELD;
        end else if (db_q == DB_LAST) begin
          db_d    = '0;
          held_d  = 1'b0;
          dwell_d = '0;
          row_d   = row_next;
          state_d = SCAN;
        end else begin
          db_d = db_q + BW'(1);
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= SCAN;
      row_q     <= '0;
      dwell_q   <= '0;
      db_q      <= '0;
      col_q     <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      dwell_q   <= dwell_d;
      db_q      <= db_d;
      col_q     <= col_d;
      key_code  <= code_d;
      key_valid <= valid_d;
      key_held  <= held_d;
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rep_q <= '0;
    else        rep_q <= rep_d;
  end
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical 4x4 key-matrix model drives cols
// from rows; randomized presses are checked against expected key behaviour.
module tb_keypad_scanner;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] cols;
  logic [3:0] rows;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [3:0][3:0] keys = '0;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .ROWS            (ROWS),
    .COLS            (COLS),
    .SCAN_DIV        (4),
    .DEBOUNCE_CYCLES (8),
    .REPEAT_CYCLES   (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cols      (cols),
    .rows      (rows),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  // A closed key shorts its column low only while its row is driven low.
  always_comb begin
    cols = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (keys[r][c] && !rows[r]) cols[c] = 1'b0;
  end

  always @(negedge clk) begin
    if (reset && key_valid) pulses++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int exp_rows(input int r);
    return 15 - (1 << r);
  endfunction

  task automatic wait_strobe(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick(1);
      if (key_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_release(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick(1);
      if (!key_held) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic press_trial(input int r, input int c, input int hold);
    bit ok;
    int p0;
    keys = '0;
    tick($urandom_range(0, 15));
    p0 = pulses;
    keys[r][c] = 1'b1;
    wait_strobe(40, ok);
    chk("strobe", int'(ok), 1);
    chk("code", int'(key_code), r * COLS + c);
    chk("held", int'(key_held), 1);
    tick(hold);
    chk("frozen", int'(rows), exp_rows(r));
    keys = '0;
    wait_release(20, ok);
    chk("release", int'(ok), 1);
    chk("one_pulse", pulses - p0, 1);
  endtask

  initial begin
    bit ok;
    int p0;
    int held_min;
    int next_rows;

    #2 reset = 1'b0;
    tick(3);
    chk("rst_rows", int'(rows), 14);
    chk("rst_valid", int'(key_valid), 0);
    chk("rst_held", int'(key_held), 0);
    chk("rst_code", int'(key_code), 0);

    // Idle scan: each row is driven for four cycles in turn.
    @(negedge clk) reset = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick(1);
      chk("idle_scan", int'(rows), exp_rows((k / 4) % 4));
    end

    press_trial(2, 1, 20);

    // Press bounce: three cycles low on row 2 must not be accepted.
    for (int i = 0; i < 20 && rows == 4'b1011; i++) tick(1);
    for (int i = 0; i < 20 && rows != 4'b1011; i++) tick(1);
    p0 = pulses;
    keys[2][1] = 1'b1;
    tick(3);
    keys = '0;
    next_rows = 11;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (next_rows == 11 && rows != 4'b1011) next_rows = int'(rows);
      chk("bounce_held", int'(key_held), 0);
    end
    chk("bounce_pulses", pulses - p0, 0);
    chk("bounce_next_row", next_rows, 7);

    // Release bounce: a 5-cycle release gap must not drop key_held.
    p0 = pulses;
    keys[2][1] = 1'b1;
    wait_strobe(40, ok);
    chk("rb_strobe", int'(ok), 1);
    tick(3);
    keys = '0;
    held_min = 1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (!key_held) held_min = 0;
    end
    keys[2][1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (!key_held) held_min = 0;
    end
    chk("rb_held_thru_gap", held_min, 1);
    keys = '0;
    tick(8);
    chk("rb_held_early", int'(key_held), 1);
    tick(6);
    chk("rb_held_fall", int'(key_held), 0);
    chk("rb_pulses", pulses - p0, 1);

    // Two keys on row 1: lowest column wins; later keys are locked out.
    keys[1][0] = 1'b1;
    keys[1][3] = 1'b1;
    wait_strobe(40, ok);
    chk("mk_strobe", int'(ok), 1);
    chk("mk_code", int'(key_code), 4);
    tick(1);
    p0 = pulses;
    keys[3][2] = 1'b1;
    tick(20);
    chk("mk_lockout", pulses - p0, 0);
    chk("mk_code_hold", int'(key_code), 4);
    chk("mk_rows", int'(rows), exp_rows(1));
    chk("mk_held", int'(key_held), 1);
    keys = '0;
    wait_release(20, ok);
    chk("mk_release", int'(ok), 1);

    // Asynchronous reset while held, checked before the next edge.
    keys[0][2] = 1'b1;
    wait_strobe(40, ok);
    chk("ar_strobe", int'(ok), 1);
    tick(2);
    #3 reset = 1'b0;
    #1;
    chk("ar_rows", int'(rows), 14);
    chk("ar_held", int'(key_held), 0);
    chk("ar_valid", int'(key_valid), 0);
    chk("ar_code", int'(key_code), 0);
    tick(2);
    keys = '0;
    @(negedge clk) reset = 1'b1;

    for (int t = 0; t < 10; t++)
      press_trial($urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(5, 25));

    // Long hold: 100 cycles after acceptance.
    keys = '0;
    p0 = pulses;
    keys[3][3] = 1'b1;
    wait_strobe(40, ok);
    chk("long_strobe", int'(ok), 1);
    tick(100);
    keys = '0;
    wait_release(20, ok);
    chk("long_release", int'(ok), 1);
    chk("long_code", int'(key_code), 15);
`ifdef KEYPAD_AUTOREPEAT_EN
    chk("long_pulses", pulses - p0, 4);
`else
    chk("long_pulses", pulses - p0, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
